gat_subgraph_scheduler: RTL and testbench

- Consumes the per-node node_info stream (row_length, num_of_nodes, source_node_flag) in node order.
- For each node, emits an H-row descriptor giving the start address of its sparse row in the H data BRAM, plus its row length.
- On subgraph close, emits a subgraph descriptor (index, node count, base address, total nnz) for the DMVM/softmax/aggregator scheduling.
- Generalises the fixed node_info layout into a parametrised, error-checking scheduler between the node_info BRAM reader and the SPMM/DMVM front end.

---
 rtl/gat_subgraph_scheduler_pkg.sv | 35 +++
 rtl/gat_subgraph_scheduler_addr_acc.sv | 47 ++++
 rtl/gat_subgraph_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_gat_subgraph_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_subgraph_scheduler_pkg.sv
// Shared types and widths for the GAT subgraph scheduler: node_info layout,
// subgraph descriptor, FSM states and derived widths.
package gat_subgraph_scheduler_pkg;

  localparam int unsigned ROW_LEN_WIDTH  = 5;
  localparam int unsigned NUM_NODE_WIDTH = 5;
  localparam int unsigned MAX_NODES      = 18;
  localparam int unsigned H_DATA_DEPTH   = 2105;
  localparam int unsigned H_DATA_ADDR_W  = $clog2(H_DATA_DEPTH);
  localparam int unsigned NUM_SUBGRAPHS  = 21;
  localparam int unsigned SG_IDX_W       = $clog2(NUM_SUBGRAPHS);
  // Wide enough for MAX_NODES rows of maximum length (18*31 = 558 < 1024).
  localparam int unsigned NNZ_W          = ROW_LEN_WIDTH + NUM_NODE_WIDTH;

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0]  row_length;
    logic [NUM_NODE_WIDTH-1:0] num_of_nodes;
    logic                      source_node_flag;
  } node_info_t;

  typedef struct packed {
    logic [SG_IDX_W-1:0]       idx;
    logic [NUM_NODE_WIDTH-1:0] num_nodes;
    logic [H_DATA_ADDR_W-1:0]  base_addr;
    logic [NNZ_W-1:0]          nnz;
    logic                      truncated;
  } sg_desc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/gat_subgraph_scheduler_addr_acc.sv
// gat_addr_wrap_acc: running H data BRAM address, advanced by each row length
// and wrapped modulo DEPTH; clear has priority over load, load over add.
module gat_addr_wrap_acc #(
  parameter int unsigned DEPTH  = 2105,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned INC_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              add_en_i,
  input  logic [INC_W-1:0]  add_val_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   sum;

  // Increment is always below DEPTH, so a single conditional subtract wraps.
  always_comb begin
    sum = {1'b0, addr_q} + (ADDR_W+1)'(add_val_i);
    if (sum >= (ADDR_W+1)'(DEPTH)) begin
      sum = sum - (ADDR_W+1)'(DEPTH);
    end
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (add_en_i) begin
      addr_d = sum[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (clear_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/gat_subgraph_scheduler.sv
// Turns the node_info stream into per-node H-row descriptors and, on subgraph
// close, a subgraph descriptor for the DMVM/softmax/aggregator stages.
module gat_subgraph_scheduler
  import gat_subgraph_scheduler_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  node_info_t               in_node_info,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [H_DATA_ADDR_W-1:0] row_addr,
  output logic [ROW_LEN_WIDTH-1:0] row_len,
  output logic                     row_is_source,
  output logic                     sg_valid,
  input  logic                     sg_ready,
  output sg_desc_t                 sg_desc,
  output logic                     done,
  output logic                     err_count,
  output logic                     err_orphan
);

  sched_state_e               state_q, state_d;
  logic [NUM_NODE_WIDTH-1:0]  target_q, target_d, node_cnt_q, node_cnt_d;
  logic [H_DATA_ADDR_W-1:0]   base_q, base_d;
  logic [NNZ_W-1:0]           nnz_acc_q, nnz_acc_d;
  logic [SG_IDX_W-1:0]        sg_idx_q, sg_idx_d;
  logic                       row_valid_q, row_valid_d, row_src_q, row_src_d;
  logic [H_DATA_ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [ROW_LEN_WIDTH-1:0]   row_len_q, row_len_d;
  logic                       sg_valid_q, sg_valid_d;
  sg_desc_t                   sg_desc_q, sg_desc_d;
  logic                       done_q, done_d, err_count_q, err_count_d;
  logic                       err_orphan_q, err_orphan_d;
  logic [H_DATA_ADDR_W-1:0]   addr_ptr;
  logic                       src_blocked, ready_int, accept, legal_cnt;
  logic [NUM_NODE_WIDTH-1:0]  cnt_inc;
  logic [NNZ_W-1:0]           len_ext;

  gat_addr_wrap_acc #(
    .DEPTH (H_DATA_DEPTH),
    .ADDR_W(H_DATA_ADDR_W),
    .INC_W (ROW_LEN_WIDTH)
  ) u_addr_acc (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .load_i    (1'b0),
    .load_val_i('0),
    .add_en_i  (accept),
    .add_val_i (in_node_info.row_length),
    .addr_o    (addr_ptr)
  );

  // A source arriving mid-collection closes the open subgraph instead of
  // being consumed; it is accepted later from IDLE.
  assign src_blocked = (state_q == COLLECT) && in_valid && in_node_info.source_node_flag;
  assign ready_int   = rst_n && !done_q && (state_q != EMIT) &&
                       (!row_valid_q || row_ready) && !src_blocked;
  assign accept      = in_valid && ready_int;
  assign legal_cnt   = (in_node_info.num_of_nodes != '0) &&
                       (in_node_info.num_of_nodes <= NUM_NODE_WIDTH'(MAX_NODES));
  assign cnt_inc     = node_cnt_q + NUM_NODE_WIDTH'(1);
  assign len_ext     = NNZ_W'(in_node_info.row_length);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    node_cnt_d   = node_cnt_q;
    base_d       = base_q;
    nnz_acc_d    = nnz_acc_q;
    sg_idx_d     = sg_idx_q;
    row_valid_d  = row_valid_q;
    row_addr_d   = row_addr_q;
    row_len_d    = row_len_q;
    row_src_d    = row_src_q;
    sg_valid_d   = sg_valid_q;
    sg_desc_d    = sg_desc_q;
    done_d       = done_q;
    err_count_d  = err_count_q;
    err_orphan_d = err_orphan_q;

    if (accept) begin
      row_valid_d = 1'b1;
      row_addr_d  = addr_ptr;
      row_len_d   = in_node_info.row_length;
      row_src_d   = in_node_info.source_node_flag;
    end else if (row_ready) begin
      row_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_node_info.source_node_flag) begin
            err_orphan_d = 1'b1;
          end else if (!legal_cnt) begin
            err_count_d = 1'b1;
          end else begin
            target_d   = in_node_info.num_of_nodes;
            base_d     = addr_ptr;
            node_cnt_d = NUM_NODE_WIDTH'(1);
            nnz_acc_d  = len_ext;
            if (in_node_info.num_of_nodes == NUM_NODE_WIDTH'(1)) begin
              state_d             = EMIT;
              sg_valid_d          = 1'b1;
              sg_desc_d.idx       = sg_idx_q;
              sg_desc_d.num_nodes = in_node_info.num_of_nodes;
              sg_desc_d.base_addr = addr_ptr;
              sg_desc_d.nnz       = len_ext;
              sg_desc_d.truncated = 1'b0;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end
      COLLECT: begin
        if (src_blocked) begin
          state_d             = EMIT;
          sg_valid_d          = 1'b1;
          sg_desc_d.idx       = sg_idx_q;
          sg_desc_d.num_nodes = node_cnt_q;
          sg_desc_d.base_addr = base_q;
          sg_desc_d.nnz       = nnz_acc_q;
          sg_desc_d.truncated = 1'b1;
        end else if (accept) begin
          node_cnt_d = cnt_inc;
          nnz_acc_d  = nnz_acc_q + len_ext;
          if (cnt_inc == target_q) begin
            state_d             = EMIT;
            sg_valid_d          = 1'b1;
            sg_desc_d.idx       = sg_idx_q;
            sg_desc_d.num_nodes = target_q;
            sg_desc_d.base_addr = base_q;
            sg_desc_d.nnz       = nnz_acc_q + len_ext;
            sg_desc_d.truncated = 1'b0;
          end
        end
      end
      EMIT: begin
        if (sg_ready) begin
          sg_valid_d = 1'b0;
          sg_idx_d   = sg_idx_q + SG_IDX_W'(1);
          state_d    = IDLE;
          if (sg_idx_q == SG_IDX_W'(NUM_SUBGRAPHS - 1)) begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      node_cnt_q   <= '0;
      base_q       <= '0;
      nnz_acc_q    <= '0;
      sg_idx_q     <= '0;
      row_valid_q  <= 1'b0;
      row_addr_q   <= '0;
      row_len_q    <= '0;
      row_src_q    <= 1'b0;
      sg_valid_q   <= 1'b0;
      sg_desc_q    <= '0;
      done_q       <= 1'b0;
      err_count_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      target_q     <= '0;
      node_cnt_q   <= '0;
      base_q       <= '0;
      nnz_acc_q    <= '0;
      sg_idx_q     <= '0;
      row_valid_q  <= 1'b0;
      row_addr_q   <= '0;
      row_len_q    <= '0;
      row_src_q    <= 1'b0;
      sg_valid_q   <= 1'b0;
      sg_desc_q    <= '0;
      done_q       <= 1'b0;
      err_count_q  <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      node_cnt_q   <= node_cnt_d;
      base_q       <= base_d;
      nnz_acc_q    <= nnz_acc_d;
      sg_idx_q     <= sg_idx_d;
      row_valid_q  <= row_valid_d;
      row_addr_q   <= row_addr_d;
      row_len_q    <= row_len_d;
      row_src_q    <= row_src_d;
      sg_valid_q   <= sg_valid_d;
      sg_desc_q    <= sg_desc_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign in_ready      = ready_int;
  assign row_valid     = row_valid_q;
  assign row_addr      = row_addr_q;
  assign row_len       = row_len_q;
  assign row_is_source = row_src_q;
  assign sg_valid      = sg_valid_q;
  assign sg_desc       = sg_desc_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_gat_subgraph_scheduler.sv
// Directed bench for gat_subgraph_scheduler with hand-computed expectations.
module tb_gat_subgraph_scheduler;
  import gat_subgraph_scheduler_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n, clear, in_valid, row_ready, sg_ready;
  logic                     in_ready, row_valid, row_is_source, sg_valid;
  logic                     done, err_count, err_orphan;
  node_info_t               in_node_info;
  logic [H_DATA_ADDR_W-1:0] row_addr;
  logic [ROW_LEN_WIDTH-1:0] row_len;
  sg_desc_t                 sg_desc;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  gat_subgraph_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_node_info (in_node_info),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_addr     (row_addr),
    .row_len      (row_len),
    .row_is_source(row_is_source),
    .sg_valid     (sg_valid),
    .sg_ready     (sg_ready),
    .sg_desc      (sg_desc),
    .done         (done),
    .err_count    (err_count),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic src, input int unsigned num, input int unsigned len);
    in_valid                      = 1'b1;
    in_node_info.row_length       = ROW_LEN_WIDTH'(len);
    in_node_info.num_of_nodes     = NUM_NODE_WIDTH'(num);
    in_node_info.source_node_flag = src;
  endtask

  task automatic chk_row(input string tag, input int unsigned addr, input int unsigned len);
    chk({tag, ".valid"}, 32'(row_valid), 1);
    chk({tag, ".addr"},  32'(row_addr), addr);
    chk({tag, ".len"},   32'(row_len), len);
  endtask

  task automatic chk_sg(input string tag, input int unsigned idx, input int unsigned n,
                        input int unsigned base, input int unsigned nnz, input int unsigned tr);
    chk({tag, ".valid"}, 32'(sg_valid), 1);
    chk({tag, ".idx"},   32'(sg_desc.idx), idx);
    chk({tag, ".num"},   32'(sg_desc.num_nodes), n);
    chk({tag, ".base"},  32'(sg_desc.base_addr), base);
    chk({tag, ".nnz"},   32'(sg_desc.nnz), nnz);
    chk({tag, ".trunc"}, 32'(sg_desc.truncated), tr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; row_ready = 1'b1; sg_ready = 1'b1;
    in_node_info = '0;
    #2;
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.row_valid", 32'(row_valid), 0);
    chk("rst.sg_valid", 32'(sg_valid), 0);
    chk("rst.done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle.in_ready", 32'(in_ready), 1);
    chk("idle.errs", 32'({err_count, err_orphan}), 0);

    // 3-node subgraph, lengths 4,2,5
    drive(1'b1, 3, 4); tick();
    chk_row("t1.r0", 0, 4);
    chk("t1.r0.src", 32'(row_is_source), 1);
    chk("t1.r0.sgv", 32'(sg_valid), 0);
    drive(1'b0, 0, 2); tick();
    chk_row("t1.r1", 4, 2);
    chk("t1.r1.src", 32'(row_is_source), 0);
    drive(1'b0, 0, 5); tick();
    chk_row("t1.r2", 6, 5);
    chk_sg("t1.sg", 0, 3, 0, 11, 0);
    in_valid = 1'b0; #1;
    chk("t1.emit.in_ready", 32'(in_ready), 0);
    tick();
    chk("t1.hs.sgv", 32'(sg_valid), 0);
    chk("t1.hs.in_ready", 32'(in_ready), 1);

    // clear restarts the pass
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr1.row_valid", 32'(row_valid), 0);

    // single-node then 2-node subgraph
    drive(1'b1, 1, 7); tick();
    chk_row("t2.r0", 0, 7);
    chk_sg("t2.sg0", 0, 1, 0, 7, 0);
    in_valid = 1'b0; tick();
    drive(1'b1, 2, 1); tick();
    chk_row("t2.r1", 7, 1);
    chk("t2.r1.sgv", 32'(sg_valid), 0);
    drive(1'b0, 0, 1); tick();
    chk_row("t2.r2", 8, 1);
    chk_sg("t2.sg1", 1, 2, 7, 2, 0);
    in_valid = 1'b0; tick();

    // early source truncates an open subgraph (addr 9, idx 2)
    drive(1'b1, 4, 3); tick();
    chk_row("t3.r0", 9, 3);
    drive(1'b0, 0, 2); tick();
    chk_row("t3.r1", 12, 2);
    drive(1'b1, 2, 6); #1;
    chk("t3.blk.in_ready", 32'(in_ready), 0);
    tick();
    chk_sg("t3.sg", 2, 2, 9, 5, 1);
    chk("t3.emit.in_ready", 32'(in_ready), 0);
    chk("t3.emit.row_valid", 32'(row_valid), 0);
    tick();
    chk("t3.idle.in_ready", 32'(in_ready), 1);
    tick();
    chk_row("t3.r2", 14, 6);
    chk("t3.r2.src", 32'(row_is_source), 1);
    drive(1'b0, 0, 1); tick();
    chk_row("t3.r3", 20, 1);
    chk_sg("t3.sg2", 3, 2, 14, 7, 0);
    in_valid = 1'b0; tick();

    // error flags (addr 21)
    drive(1'b1, 0, 3); tick();
    chk_row("t4.r0", 21, 3);
    chk("t4.err_count", 32'(err_count), 1);
    chk("t4.err_orphan0", 32'(err_orphan), 0);
    drive(1'b0, 0, 2); tick();
    chk_row("t4.r1", 24, 2);
    chk("t4.err_orphan", 32'(err_orphan), 1);
    chk("t4.sgv", 32'(sg_valid), 0);

    // wrap: advance from 26 to 2100 at full throughput
    for (int i = 0; i < 66; i++) begin
      drive(1'b0, 0, 31); tick();
    end
    chk_row("t5.last31", 2041, 31);
    drive(1'b0, 0, 28); tick();
    chk_row("t5.r28", 2072, 28);
    drive(1'b0, 0, 10); tick();
    chk_row("t5.r10", 2100, 10);
    drive(1'b0, 0, 0); tick();
    chk_row("t5.wrap", 5, 0);
    drive(1'b0, 0, 3); tick();
    chk_row("t5.zero", 5, 3);
    chk("t5.sticky", 32'({err_count, err_orphan}), 3);

    // backpressure on the row slot (addr 8)
    in_valid = 1'b0; tick();
    row_ready = 1'b0;
    drive(1'b0, 0, 4); #1;
    chk("t6.empty.in_ready", 32'(in_ready), 1);
    tick();
    chk_row("t6.r0", 8, 4);
    drive(1'b0, 0, 6); #1;
    chk("t6.full.in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_row("t6.hold", 8, 4);
      chk("t6.hold.in_ready", 32'(in_ready), 0);
    end
    row_ready = 1'b1; #1;
    chk("t6.rel.in_ready", 32'(in_ready), 1);
    tick();
    chk_row("t6.refill", 12, 6);
    in_valid = 1'b0; tick();
    chk("t6.drain", 32'(row_valid), 0);

    // full pass of single-node subgraphs
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr2.errs", 32'({err_count, err_orphan}), 0);
    chk("clr2.done", 32'(done), 0);
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, 1, 1); tick();
      chk_sg("t7.sg", i, 1, i, 1, 0);
      chk("t7.row_addr", 32'(row_addr), i);
      if (i == 20) begin
        sg_ready = 1'b0;
        tick(); tick();
        chk_sg("t7.hold", 20, 1, 20, 1, 0);
        chk("t7.hold.done", 32'(done), 0);
        sg_ready = 1'b1;
      end
      tick();
    end
    chk("t7.done", 32'(done), 1);
    chk("t7.in_ready", 32'(in_ready), 0);
    chk("t7.sgv", 32'(sg_valid), 0);
    tick();
    chk("t7.noacc", 32'(row_valid), 0);
    chk("t7.done_sticky", 32'(done), 1);

    clear = 1'b1; tick(); clear = 1'b0; in_valid = 1'b0; #1;
    chk("clr3.done", 32'(done), 0);
    chk("clr3.in_ready", 32'(in_ready), 1);
    drive(1'b1, 1, 5); tick();
    chk_row("t8.r0", 0, 5);
    chk_sg("t8.sg", 0, 1, 0, 5, 0);
    in_valid = 1'b0; tick();

    // async reset in the middle of a collection
    row_ready = 1'b0;
    drive(1'b1, 3, 2); tick();
    in_valid = 1'b0;
    chk_row("t9.r0", 5, 2);
    #2 rst_n = 1'b0; #1;
    chk("t9.row_valid", 32'(row_valid), 0);
    chk("t9.row_addr", 32'(row_addr), 0);
    chk("t9.row_len", 32'(row_len), 0);
    chk("t9.row_src", 32'(row_is_source), 0);
    chk("t9.sg", 32'({sg_valid, sg_desc}), 0);
    chk("t9.flags", 32'({done, err_count, err_orphan, in_ready}), 0);
    #3 rst_n = 1'b1;
    row_ready = 1'b1;
    tick();
    drive(1'b1, 1, 3); tick();
    chk_row("t9.after", 0, 3);
    chk_sg("t9.sg0", 0, 1, 0, 3, 0);
    in_valid = 1'b0; tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
